// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch bank controller.
// FSM states, op encodings, requester ids, helpers.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_arb.sv
// sr_rr_arb2: 2-way round-robin arbiter, prio flop.
// Ports: clk, rst_n, en, a/b_valid in; a/b_ready, gnt_id out.
module sr_rr_arb2
  import sr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready,
  output logic gnt_id
);

  logic prio_q, prio_d;
  logic a_g, b_g;

  always_comb begin
    a_g = a_valid &
          (!b_valid || prio_q == REQ_A);
    b_g = b_valid &
          (!a_valid || prio_q == REQ_B);
    a_ready = en & a_g;
    b_ready = en & b_g;
    gnt_id  = b_ready ? REQ_B : REQ_A;
    // Winner drops to the back of the line.
    prio_d = prio_q;
    unique case (1'b1)
      a_ready: prio_d = REQ_B;
      b_ready: prio_d = REQ_A;
      default: prio_d = prio_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= REQ_A;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// SR latch bank controller: arbitrates A/B, pulses S/R.
// Ports: a/b req, s_o/r_o/q_i bank, busy/done/done_id/err.
// Option: SR_LATCH_VERIFY_EN enables q read-back check.
module sr_latch_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N          = 6,
  parameter int IW         = (N > 1) ? $clog2(N) : 1,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic          a_op,
  input  logic [IW-1:0] a_idx,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic          b_op,
  input  logic [IW-1:0] b_idx,
  output logic          b_ready,
  output logic [N-1:0]  s_o,
  output logic [N-1:0]  r_o,
  input  logic [N-1:0]  q_i,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic          err
);

  localparam int CMAX = max2(PULSE_CYC, SETTLE_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [N-1:0] ONE =
    {{(N-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic            id_q, id_d;
  logic            oor_q, oor_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    s_q, s_d;
  logic [N-1:0]    r_q, r_d;
  logic            en, acc, gnt_id;
  logic            last_cnt;

  assign en = (state_q == ST_IDLE);

  sr_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready),
    .gnt_id  (gnt_id)
  );

  assign acc      = a_ready | b_ready;
  assign last_cnt = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          id_d  = gnt_id;
          op_d  = (gnt_id == REQ_B) ? b_op : a_op;
          idx_d = (gnt_id == REQ_B) ? b_idx : a_idx;
          oor_d = (int'(idx_d) >= N);
          cnt_d = CW'(PULSE_CYC);
          // Bad index never touches the bank.
          state_d = oor_d ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (last_cnt) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (last_cnt) state_d = ST_DONE;
        else          cnt_d = cnt_q - CW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Drives are registered from next state so
    // S and R are clean flop outputs, one-hot.
    s_d = '0;
    r_d = '0;
    if (state_d == ST_DRIVE) begin
      if (op_d == OP_SET) s_d = ONE << idx_d;
      else                r_d = ONE << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RST;
      id_q    <= REQ_A;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      id_q    <= id_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign s_o     = s_q;
  assign r_o     = r_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign done_id = done & id_q;

`ifdef SR_LATCH_VERIFY_EN
  logic qs_q, qs_d;

  always_comb begin
    qs_d = qs_q;
    if (state_q == ST_SETTLE && last_cnt)
      qs_d = q_i[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) qs_q <= 1'b0;
    else        qs_q <= qs_d;
  end

  assign err = done & (oor_q | (qs_q != op_q));
`else
  logic unused_q;
  assign unused_q = ^q_i;
  assign err = done & oor_q;
`endif

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl: directed plus random
// stimulus against an offset-based behavioural model.
module tb_sr_latch_bank_ctrl;

  localparam int N  = 6;
  localparam int IW = 3;
  localparam int P  = 2;
  localparam int S  = 1;
`ifdef SR_LATCH_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_op, a_ready;
  logic          b_valid, b_op, b_ready;
  logic [IW-1:0] a_idx, b_idx;
  logic [N-1:0]  s_o, r_o, q_i;
  logic          busy, done, done_id, err;

  sr_latch_bank_ctrl #(
    .N(N), .IW(IW),
    .PULSE_CYC(P), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_op(a_op),
    .a_idx(a_idx), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op),
    .b_idx(b_idx), .b_ready(b_ready),
    .s_o(s_o), .r_o(r_o), .q_i(q_i),
    .busy(busy), .done(done),
    .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: an op accepted at an edge occupies the
  // following cycles d=1..end; drive for d<=P, q
  // sampled at end of d=P+S, done at d=end.
  bit m_act = 0;
  int m_d, m_end, m_idx;
  bit m_op, m_id, m_oor, m_qs, m_prio = 0;

  function automatic logic [1:0] grant(
      logic av, logic bv, bit pr);
    logic ga;
    ga = av && (!bv || pr == 1'b0);
    return {ga, bv && !ga};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_act  = 0;
      m_prio = 0;
    end else if (m_act) begin
      if (!m_oor && m_d == P + S) m_qs = q_i[m_idx];
      if (m_d == m_end) m_act = 0;
      else              m_d++;
    end else begin
      g = grant(a_valid, b_valid, m_prio);
      if (g != 2'b00) begin
        m_id   = g[0];
        m_op   = g[0] ? b_op : a_op;
        m_idx  = g[0] ? int'(b_idx) : int'(a_idx);
        m_oor  = (m_idx >= N);
        m_end  = m_oor ? 1 : P + S + 1;
        m_act  = 1;
        m_d    = 1;
        m_prio = !g[0];
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] es, er;
    logic [1:0]   g;
    logic         ed, ee;
    if (chk_en) begin
      es = '0;
      er = '0;
      if (m_act && !m_oor && m_d <= P) begin
        if (m_op) es = N'(1) << m_idx;
        else      er = N'(1) << m_idx;
      end
      ed = m_act && (m_d == m_end);
      g  = m_act ? 2'b00 :
           grant(a_valid, b_valid, m_prio);
      chk("busy", 64'(busy), 64'(m_act));
      chk("s_o", 64'(s_o), 64'(es));
      chk("r_o", 64'(r_o), 64'(er));
      chk("s_and_r", 64'(s_o & r_o), 64'd0);
      chk("ready", 64'({a_ready, b_ready}), 64'(g));
      chk("done", 64'(done), 64'(ed));
      if (ed) begin
        ee = m_oor || (VERIFY && (m_qs != m_op));
        chk("done_id", 64'(done_id), 64'(m_id));
        chk("err", 64'(err), 64'(ee));
      end
    end
  end

  initial begin
    int nd, last_drv, ng;
    logic [1:0] ids;
    int gseq [4];
    logic ga, gb, a_acc, b_acc;
    rst_n = 0; a_valid = 0; b_valid = 0;
    a_op = 0; b_op = 0; a_idx = 0; b_idx = 0;
    q_i = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1; chk_en = 1;

    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_s", 64'(s_o), 0);
    chk("rst_r", 64'(r_o), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_done_id", 64'(done_id), 0);
    chk("rst_err", 64'(err), 0);

    // Single set of idx3, q reads back 1.
    @(posedge clk);
    #2 a_valid = 1; a_op = 1; a_idx = 3; q_i = '1;
    @(negedge clk);
    chk("t1_a_ready", 64'(a_ready), 1);
    @(posedge clk);
    #2 a_valid = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t1_s", 64'(s_o), (c <= 2) ? 64'h08 : 64'h0);
      chk("t1_r", 64'(r_o), 0);
      chk("t1_done", 64'(done), 64'(c == 4));
      if (c == 4) begin
        chk("t1_done_id", 64'(done_id), 0);
        chk("t1_err", 64'(err), 0);
      end
    end

    // Out of range index from B.
    @(posedge clk);
    #2 b_valid = 1; b_op = 1; b_idx = 7;
    @(posedge clk);
    #2 b_valid = 0;
    @(negedge clk);
    chk("t2_done", 64'(done), 1);
    chk("t2_err", 64'(err), 1);
    chk("t2_done_id", 64'(done_id), 1);
    chk("t2_sr", 64'(s_o | r_o), 0);
    @(negedge clk);
    chk("t2_idle", 64'(busy), 0);

    // Same idx, opposite ops, both valid.
    @(posedge clk);
    #2 a_valid = 1; a_op = 1; a_idx = 2;
    b_valid = 1; b_op = 0; b_idx = 2;
    nd = 0; last_drv = 0; ids = 2'b00;
    for (int c = 0; c < 30 && nd < 2; c++) begin
      @(negedge clk);
      if (c == 0)
        chk("t3_first", 64'({a_ready, b_ready}), 64'h2);
      ga = a_valid && a_ready;
      gb = b_valid && b_ready;
      if (s_o[2]) last_drv = 1;
      if (r_o[2]) last_drv = 2;
      if (done) begin
        ids[nd] = done_id;
        nd++;
      end
      @(posedge clk);
      #2;
      if (ga) a_valid = 0;
      if (gb) b_valid = 0;
    end
    chk("t3_ndone", 64'(nd), 2);
    chk("t3_ids", 64'(ids), 64'h2);
    chk("t3_last_drv", 64'(last_drv), 2);

    // Fairness under continuous contention.
    a_valid = 1; a_op = 1; a_idx = 0;
    b_valid = 1; b_op = 0; b_idx = 1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (a_ready) begin gseq[ng] = 0; ng++; end
      else if (b_ready) begin gseq[ng] = 1; ng++; end
      @(posedge clk);
      #2;
      if (ng == 4) begin a_valid = 0; b_valid = 0; end
    end
    chk("t4_ngrant", 64'(ng), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_grant", 64'(gseq[i]), 64'(i & 1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("t4_drain", 64'(busy), 0);

    // Reset in the middle of the S pulse.
    @(posedge clk);
    #2 a_valid = 1; a_op = 1; a_idx = 0;
    @(posedge clk);
    #2 a_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("t5_pulse", 64'(s_o), 64'h01);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("t5_s_rel", 64'(s_o), 0);
    chk("t5_busy", 64'(busy), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_no_done", 64'(done), 0);
    end
    @(posedge clk);
    #2 a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("t5_prio_a", 64'({a_ready, b_ready}), 64'h2);
    @(posedge clk);
    #2 a_valid = 0; b_valid = 0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      @(posedge clk);
      #2;
      rst_n = ($urandom_range(0, 399) != 0);
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_op    = 1'($urandom);
        a_idx   = 3'($urandom_range(0, 7));
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_op    = 1'($urandom);
        b_idx   = 3'($urandom_range(0, 7));
      end
      q_i = N'($urandom);
    end
    rst_n = 1; a_valid = 0; b_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank_ctrl.md
Name: sr_latch_bank_ctrl

Overview:
Clocked controller that sequences set/reset pulses into a bank of N external SR latches on behalf of two requesters (A, B).
- Round-robin arbitration between A and B.
- Fixed-width S or R pulses; S and R are never driven together, so the forbidden S=R=1 input can never occur.
- Optional read-back check of each latch's q after a settle time.
- Sits between software/control-side requesters and the latch bank.

Parameters:
N, 6, number of latches in the bank (2..64)
IW, $clog2(N) (min 1), index width
PULSE_CYC, 2, cycles S or R is held high (>=1)
SETTLE_CYC, 1, cycles after the pulse before q is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
a_valid  in  1  requester A has an op
a_op  in  1  A op: 1=set, 0=reset
a_idx  in  IW  A target latch
a_ready  out  1  A op accepted this cycle
b_valid  in  1  requester B has an op
b_op  in  1  B op: 1=set, 0=reset
b_idx  in  IW  B target latch
b_ready  out  1  B op accepted this cycle
s_o  out  N  per-latch S drive
r_o  out  N  per-latch R drive
q_i  in  N  per-latch q feedback
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_id  out  1  requester of completed op (0=A, 1=B)
err  out  1  qualified by done: op failed

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, s_o=0, r_o=0, done=0, done_id=0, err=0, busy=0, prio=A. Reset mid-operation releases S/R on that same edge. No done pulse is produced for an aborted op.
- States: IDLE, DRIVE, SETTLE, DONE.
- IDLE, arbitration and handshake:
  - ready outputs are combinational and asserted only in IDLE.
  - If exactly one valid is high, that requester gets ready=1.
  - If both are high, the requester named by prio gets ready, then prio flips to the other.
  - Accept = valid&&ready. On accept: op, idx and id are registered; prio updates; state goes to DRIVE.
  - A valid held while not granted must keep op/idx stable.
- Out-of-range idx (idx>=N): accepted, S/R not driven, IDLE goes straight to DONE with err=1.
- DRIVE:
  - Exactly one bit of s_o (op=1) or r_o (op=0), at idx, is high for PULSE_CYC cycles.
  - All other bits stay 0. s_o&r_o==0 at all times.
  - Then state goes to SETTLE with all drives 0.
- SETTLE: all drives 0 for SETTLE_CYC cycles. On the last SETTLE edge, q_i[idx] is registered. Then state goes to DONE.
- DONE: done=1 for one cycle with done_id and err valid. Next state is IDLE.
- No accept is possible in DRIVE, SETTLE or DONE.
- Latency, accept edge to done high: PULSE_CYC+SETTLE_CYC+1 cycles.
- Throughput: one op per PULSE_CYC+SETTLE_CYC+2 cycles.
- Same idx with opposite ops from A and B in one cycle: serialized by arbitration; the last-granted op determines the final latch state.
- Counters are sized for max(PULSE_CYC,SETTLE_CYC) and count down to 1. There is no wrap-around behaviour.

Optional Feature:
Macro SR_LATCH_VERIFY_EN.
- Defined: in DONE, err=1 if the sampled q differs from op (set expects 1, reset expects 0), or if idx>=N.
- Undefined: q_i is ignored, no q sample register is built, and err=1 only for idx>=N.
- Timing and handshake are identical in both builds.

Decomposition:
- Package sr_ctrl_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, DONE)
  - op encoding constants OP_SET=1, OP_RST=0
  - requester id constants REQ_A=0, REQ_B=1
- One natural sub-module, sr_rr_arb2: 2-way round-robin arbiter with valid inputs, ready outputs and a priority flop, updated on accept.

Test Plan:
- Reset then a single set: N=6, PULSE_CYC=2, SETTLE_CYC=1, a_valid=1 op=1 idx=3 accepted at edge 0 -> s_o=6'b001000 in cycles 1-2; r_o=0 throughout; done=1, done_id=0 in cycle 4; err=0 with q_i[3]=1.
- Simultaneous requests: A set idx2 and B reset idx2 both valid after reset -> A granted first, B second; done_id sequence 0 then 1; r_o[2] pulsed last; s_o&r_o==0 every cycle.
- Fairness: A and B both valid continuously for 4 ops -> grants alternate A,B,A,B.
- Out of range: b_idx=7 with N=6 -> accepted, s_o=r_o=0, done with err=1 one cycle after accept.
- Verify (macro defined): set idx1 with q_i[1] held 0 -> done with err=1. Macro undefined: same stimulus -> err=0.
- Reset mid-DRIVE: rst_n=0 at the edge ending cycle 1 of the pulse -> s_o=0 from that edge, busy=0, no done pulse, the next request is granted to A.
